// File: rtl/bcd_to_1of8_driver_pkg.sv
// bcd_to_1of8_driver_pkg: state encodings and code limit shared by the 1-of-8 driver
package bcd_to_1of8_driver_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;
    localparam logic [3:0] BCD1OF8_MAX_CODE = 4'd7;
endpackage

// File: rtl/bcd_to_1of8_driver_onehot8_enc.sv
// onehot8_enc: combinational 3-bit code to one-hot-8 encoder
module onehot8_enc (
    input  logic [2:0] code,
    output logic [7:0] onehot
);
    assign onehot = 8'd1 << code;
endmodule

// File: rtl/bcd_to_1of8_driver.sv
// bcd_to_1of8_driver: handshaked BCD to registered one-of-8 line with hold and blanking gap
// Optional BCD1OF8_ERR_STICKY_EN adds err_clr and makes err sticky.
module bcd_to_1of8_driver
    import bcd_to_1of8_driver_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef BCD1OF8_ERR_STICKY_EN
    input  logic       err_clr,
`endif
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] bcd,
    output logic [7:0] one_of_8,
    output logic       out_valid,
    output logic       busy,
    output logic       err
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       enc;
    logic             xfer;
    logic             bad;
    logic             err_nxt;
    onehot8_enc u_enc (.code(bcd[2:0]), .onehot(enc));
    assign in_ready  = state == ST_IDLE;
    assign busy      = state != ST_IDLE;
    assign out_valid = |one_of_8;
    assign xfer      = in_valid && in_ready;
    assign bad       = bcd > BCD1OF8_MAX_CODE;
`ifdef BCD1OF8_ERR_STICKY_EN
    assign err_nxt = (xfer && bad) ? 1'b1 : err_clr ? 1'b0 : err;
`else
    assign err_nxt = xfer && bad;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            one_of_8 <= '0;
            cnt      <= '0;
            err      <= 1'b0;
        end else begin
            err <= err_nxt;
            case (state)
                ST_IDLE: if (xfer && !bad) begin
                    state    <= ST_HOLD;
                    one_of_8 <= enc;
                    cnt      <= CNT_W'(HOLD_CYCLES - 1);
                end
                ST_HOLD: if (cnt == '0) begin
                    state    <= ST_GAP;
                    one_of_8 <= '0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    one_of_8 <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_to_1of8_driver.sv
// tb_bcd_to_1of8_driver: scoreboard bench for the 1-of-8 driver
module tb_bcd_to_1of8_driver;
    localparam int H = 4;
    typedef struct {
        logic [7:0] pat;
        int         len;
    } exp_t;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       in_valid = 0;
    logic [3:0] bcd = 0;
    logic       in_ready, out_valid, busy, err;
    logic [7:0] one_of_8;
`ifdef BCD1OF8_ERR_STICKY_EN
    logic       err_clr = 0;
`endif
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_xfer = 0;
    exp_t sb[$];
    bcd_to_1of8_driver #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef BCD1OF8_ERR_STICKY_EN
        .err_clr(err_clr),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .bcd(bcd),
        .one_of_8(one_of_8),
        .out_valid(out_valid),
        .busy(busy),
        .err(err)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
        end
    endtask
    // Monitor: pops one expected pattern per output window, checks value, stability and length.
    initial begin
        logic       prev_v;
        logic [7:0] cur;
        int         run;
        int         exp_len;
        exp_t       e;
        prev_v = 0; cur = 0; run = 0; exp_len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (prev_v) check("run_len_rst", run, exp_len);
                prev_v = 0;
            end else begin
                check("onehot", $countones(one_of_8) <= 1, 1);
                check("out_valid", out_valid, one_of_8 != 0);
                check("ready_busy", in_ready, !busy);
                if (out_valid && !prev_v) begin
                    if (sb.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_out: got %0h expected none", one_of_8);
                    end else begin
                        e = sb.pop_front();
                        check("pattern", one_of_8, e.pat);
                        cur = e.pat; exp_len = e.len; run = 1;
                    end
                end else if (out_valid) begin
                    check("stable", one_of_8, cur);
                    run++;
                end else if (prev_v) begin
                    check("run_len", run, exp_len);
                end
                prev_v = out_valid;
            end
        end
    end
    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL ready_timeout: got in_ready=0 expected 1");
        end
    endtask
    task automatic send(input logic [3:0] code, input bit chk_gap, input int len);
        exp_t e;
        bcd = code;
        in_valid = 1;
        wait_ready();
        e.pat = 8'd1 << code[2:0];
        e.len = len;
        sb.push_back(e);
        @(posedge clk);
        if (chk_gap) check("xfer_spacing", cyc - last_xfer, H + 2);
        last_xfer = cyc;
        @(negedge clk);
    endtask
    task automatic send_bad(input logic [3:0] code);
        wait_ready();
        check("bad_ready_before", in_ready, 1);
        bcd = code;
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        check("bad_err", err, 1);
        check("bad_ready", in_ready, 1);
        check("bad_out", one_of_8, 8'h00);
        @(negedge clk);
`ifndef BCD1OF8_ERR_STICKY_EN
        check("bad_err_pulse", err, 0);
`endif
        check("bad_idle", busy, 0);
    endtask
    initial begin
        #12 rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_out", one_of_8, 8'h00);
            check("rst_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_err", err, 0);
            check("rst_ready", in_ready, 1);
        end
        send(4'd0, 0, H);
        for (int k = 1; k < 8; k++) send(4'(k), 1, H);
        in_valid = 0;
        send_bad(4'd9);
        send_bad(4'd15);
        send(4'd3, 0, H);
        send(4'd5, 1, H);
        in_valid = 0;
        wait_ready();
        send(4'd6, 0, 2);
        in_valid = 0;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("arst_out", one_of_8, 8'h00);
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_out", one_of_8, 8'h00);
`ifdef BCD1OF8_ERR_STICKY_EN
        send_bad(4'd12);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("sticky_hold", err, 1);
        end
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        check("sticky_clr", err, 0);
        bcd = 4'd8;
        in_valid = 1;
        err_clr = 1;
        @(negedge clk);
        in_valid = 0;
        err_clr = 0;
        check("sticky_set_wins", err, 1);
        @(negedge clk);
        check("sticky_after", err, 1);
`endif
        repeat (10) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
